solution_reader: RTL and testbench

Read-out end of the eight-queen board register. After the solver signals a finished placement, this block walks the board register column by column through its read-select port. It decodes each one-hot column word to a 3-bit row index and independently re-verifies the placement with incremental row and diagonal masks. It then presents the packed 24-bit solution on a valid/ready output handshake and keeps a running count of verified solutions.

---
 rtl/solution_reader.sv | 186 ++++++++++++++++++
 tb/tb_solution_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solution_reader.sv
// solution_reader: read-out end of the eight-queen board register.
// Walks the board one column per cycle, decodes each one-hot column word to a
// row index, re-verifies the placement with incremental row / diagonal masks,
// and presents the packed 24-bit result on a valid/ready handshake while
// keeping a saturating count of accepted error-free solutions.
module solution_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  board_row,
  output logic [2:0]  rd_col,
  output logic        busy,
  output logic        sol_valid,
  input  logic        out_ready,
  output logic [23:0] sol_rows,
  output logic        sol_error,
  output logic [2:0]  err_col,
  output logic [7:0]  sol_count
);

  localparam int unsigned N_COLS  = 8;
  localparam int unsigned DIAG_W  = 15;
  localparam logic [2:0]  LAST_COL = 3'd7;
  localparam logic [7:0]  COUNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Index of the lowest set bit; an all-zero word decodes to row 0.
  function automatic logic [2:0] lsb_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Saturating increment of the solution counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == COUNT_MAX) ? COUNT_MAX : (v + 8'd1);
  endfunction

  state_t              state_q,     state_d;
  logic [2:0]          rd_col_q,    rd_col_d;
  logic                busy_q,      busy_d;
  logic                sol_valid_q, sol_valid_d;
  logic [23:0]         sol_rows_q,  sol_rows_d;
  logic                sol_error_q, sol_error_d;
  logic [2:0]          err_col_q,   err_col_d;
  logic [7:0]          sol_count_q, sol_count_d;
  logic [N_COLS-1:0]   row_mask_q,  row_mask_d;
  logic [DIAG_W-1:0]   dsum_mask_q, dsum_mask_d;
  logic [DIAG_W-1:0]   ddif_mask_q, ddif_mask_d;

  logic [2:0] row_sel;
  logic [3:0] sum_idx;
  logic [3:0] dif_idx;
  logic       col_fail;

  // Decode the current column word and test it against the masks built so far.
  always_comb begin
    row_sel  = lsb_index(board_row);
    sum_idx  = {1'b0, row_sel} + {1'b0, rd_col_q};
    // r - c + 7 is always within 0..14, so unsigned 4-bit arithmetic is exact.
    dif_idx  = {1'b0, row_sel} + 4'd7 - {1'b0, rd_col_q};
    col_fail = !is_onehot(board_row)
             || row_mask_q[row_sel]
             || dsum_mask_q[sum_idx]
             || ddif_mask_q[dif_idx];
  end

  // Next-state and next-output computation for the read-out FSM.
  always_comb begin
    state_d     = state_q;
    rd_col_d    = rd_col_q;
    busy_d      = busy_q;
    sol_valid_d = sol_valid_q;
    sol_rows_d  = sol_rows_q;
    sol_error_d = sol_error_q;
    err_col_d   = err_col_q;
    sol_count_d = sol_count_q;
    row_mask_d  = row_mask_q;
    dsum_mask_d = dsum_mask_q;
    ddif_mask_d = ddif_mask_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_READ;
          rd_col_d    = 3'd0;
          busy_d      = 1'b1;
          sol_error_d = 1'b0;
          err_col_d   = 3'd0;
          row_mask_d  = '0;
          dsum_mask_d = '0;
          ddif_mask_d = '0;
        end
      end

      S_READ: begin
        for (int i = 0; i < N_COLS; i++) begin
          if (rd_col_q == 3'(i)) sol_rows_d[3*i +: 3] = row_sel;
        end
        // Only the first failing column is reported.
        if (col_fail && !sol_error_q) begin
          sol_error_d = 1'b1;
          err_col_d   = rd_col_q;
        end
        // Masks accumulate even for failing columns; the scan never stops early.
        row_mask_d  = row_mask_q  | (8'd1  << row_sel);
        dsum_mask_d = dsum_mask_q | (15'd1 << sum_idx);
        ddif_mask_d = ddif_mask_q | (15'd1 << dif_idx);
        if (rd_col_q == LAST_COL) begin
          state_d     = S_HOLD;
          rd_col_d    = 3'd0;
          sol_valid_d = 1'b1;
        end else begin
          rd_col_d = rd_col_q + 3'd1;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          if (!sol_error_q) sol_count_d = sat_inc(sol_count_q);
          state_d     = S_IDLE;
          sol_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        rd_col_d    = 3'd0;
        busy_d      = 1'b0;
        sol_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any scan or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_col_q    <= 3'd0;
      busy_q      <= 1'b0;
      sol_valid_q <= 1'b0;
      sol_rows_q  <= 24'd0;
      sol_error_q <= 1'b0;
      err_col_q   <= 3'd0;
      sol_count_q <= 8'd0;
      row_mask_q  <= '0;
      dsum_mask_q <= '0;
      ddif_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_col_q    <= rd_col_d;
      busy_q      <= busy_d;
      sol_valid_q <= sol_valid_d;
      sol_rows_q  <= sol_rows_d;
      sol_error_q <= sol_error_d;
      err_col_q   <= err_col_d;
      sol_count_q <= sol_count_d;
      row_mask_q  <= row_mask_d;
      dsum_mask_q <= dsum_mask_d;
      ddif_mask_q <= ddif_mask_d;
    end
  end

  assign rd_col    = rd_col_q;
  assign busy      = busy_q;
  assign sol_valid = sol_valid_q;
  assign sol_rows  = sol_rows_q;
  assign sol_error = sol_error_q;
  assign err_col   = err_col_q;
  assign sol_count = sol_count_q;

endmodule

// File: tb/tb_solution_reader.sv
// Testbench for solution_reader: scenario tasks with randomized boards checked
// against a pairwise queen-attack reference model.
module tb_solution_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  board_row;
  logic [2:0]  rd_col;
  logic        busy;
  logic        sol_valid;
  logic        out_ready;
  logic [23:0] sol_rows;
  logic        sol_error;
  logic [2:0]  err_col;
  logic [7:0]  sol_count;

  logic [7:0] bd [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference results
  logic [23:0] exp_rows;
  logic        exp_err;
  logic [2:0]  exp_col;
  int          exp_count;

  // Observed results
  int          got_lat;
  logic [23:0] got_rows;
  logic        got_err;
  logic [2:0]  got_col;
  logic [2:0]  got_rdcol;
  logic        got_busy;
  logic        got_valid_after;
  logic [7:0]  got_count;

  solution_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .board_row (board_row),
    .rd_col    (rd_col),
    .busy      (busy),
    .sol_valid (sol_valid),
    .out_ready (out_ready),
    .sol_rows  (sol_rows),
    .sol_error (sol_error),
    .err_col   (err_col),
    .sol_count (sol_count)
  );

  always #5 clk = ~clk;

  assign board_row = bd[rd_col];

  // Reference: a column fails if its word is not one-hot or its decoded row
  // shares a row or diagonal with any earlier column's decoded row.
  function automatic void compute_expected();
    int r [8];
    int d;
    logic bad;
    exp_rows = 24'd0;
    exp_err  = 1'b0;
    exp_col  = 3'd0;
    for (int c = 0; c < 8; c++) begin
      r[c] = 0;
      for (int k = 7; k >= 0; k--) if (bd[c][k]) r[c] = k;
      bad = ($countones(bd[c]) != 1);
      for (int k = 0; k < c; k++) begin
        d = r[k] - r[c];
        if (d < 0) d = -d;
        if (d == 0 || d == (c - k)) bad = 1'b1;
      end
      if (bad && !exp_err) begin
        exp_err = 1'b1;
        exp_col = 3'(c);
      end
      exp_rows[3*c +: 3] = 3'(r[c]);
    end
  endfunction

  function automatic void load_rows(input int r0, r1, r2, r3, r4, r5, r6, r7);
    int rr [8];
    rr = '{r0, r1, r2, r3, r4, r5, r6, r7};
    for (int c = 0; c < 8; c++) bd[c] = 8'd1 << rr[c];
  endfunction

  function automatic void count_model();
    if (!exp_err && exp_count < 255) exp_count++;
  endfunction

  // Pulse start, then wait (bounded) for sol_valid and capture the result.
  task automatic launch();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    got_lat = -1;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      else       begin @(posedge clk); #1; end
      if (sol_valid === 1'b1) begin got_lat = n; break; end
    end
    got_rows  = sol_rows;
    got_err   = sol_error;
    got_col   = err_col;
    got_rdcol = rd_col;
    got_busy  = busy;
  endtask

  // One-cycle handshake, then capture the post-accept state.
  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    got_valid_after = sol_valid;
    got_count       = sol_count;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 8; c++) bd[c] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({rd_col, busy, sol_valid, sol_rows, sol_error, err_col, sol_count} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_values: got rd=%0d busy=%0b vld=%0b rows=%h err=%0b col=%0d cnt=%0d, want all zero",
               rd_col, busy, sol_valid, sol_rows, sol_error, err_col, sol_count);
    end
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_valid();
    load_rows(0, 4, 7, 5, 2, 6, 1, 3);
    compute_expected();
    launch();
    n_checks++;
    if (got_lat != 8) begin n_fail++; $display("FAIL valid_latency: got %0d want 8", got_lat); end
    n_checks++;
    if (got_rows !== 24'h672BE0) begin n_fail++; $display("FAIL valid_rows: got %h want 672be0", got_rows); end
    n_checks++;
    if (got_err !== 1'b0 || got_col !== 3'd0) begin
      n_fail++; $display("FAIL valid_err: got err=%0b col=%0d want 0/0", got_err, got_col);
    end
    n_checks++;
    if (got_rdcol !== 3'd0 || got_busy !== 1'b1) begin
      n_fail++; $display("FAIL valid_hold_ctl: got rd=%0d busy=%0b want 0/1", got_rdcol, got_busy);
    end
    accept();
    count_model();
    n_checks++;
    if (got_count !== 8'(exp_count) || got_valid_after !== 1'b0) begin
      n_fail++; $display("FAIL valid_count: got cnt=%0d vld=%0b want %0d/0", got_count, got_valid_after, exp_count);
    end
  endtask

  task automatic test_row_conflict();
    for (int c = 0; c < 8; c++) bd[c] = 8'h01;
    compute_expected();
    launch();
    accept();
    count_model();
    n_checks++;
    if (got_err !== 1'b1 || got_col !== 3'd1 || got_rows !== 24'd0) begin
      n_fail++; $display("FAIL row_conflict: got err=%0b col=%0d rows=%h want 1/1/000000", got_err, got_col, got_rows);
    end
    n_checks++;
    if (got_count !== 8'(exp_count)) begin
      n_fail++; $display("FAIL row_conflict_count: got %0d want %0d", got_count, exp_count);
    end
  endtask

  task automatic test_diag_conflict();
    load_rows(0, 1, 4, 6, 3, 5, 7, 2);
    compute_expected();
    launch();
    accept();
    count_model();
    n_checks++;
    if (got_err !== 1'b1 || got_col !== 3'd1 || got_rows !== exp_rows) begin
      n_fail++; $display("FAIL diag_conflict: got err=%0b col=%0d rows=%h want 1/1/%h", got_err, got_col, got_rows, exp_rows);
    end
  endtask

  task automatic test_bad_onehot();
    load_rows(0, 4, 7, 5, 2, 6, 1, 3);
    bd[3] = 8'h00;
    compute_expected();
    launch(); accept(); count_model();
    n_checks++;
    if (got_err !== 1'b1 || got_col !== 3'd3 || got_rows[11:9] !== 3'd0) begin
      n_fail++; $display("FAIL zero_word: got err=%0b col=%0d slice3=%0d want 1/3/0", got_err, got_col, got_rows[11:9]);
    end
    load_rows(0, 4, 7, 5, 2, 6, 1, 3);
    bd[5] = 8'h41;
    compute_expected();
    launch(); accept(); count_model();
    n_checks++;
    if (got_err !== 1'b1 || got_col !== 3'd5 || got_rows[17:15] !== 3'd0) begin
      n_fail++; $display("FAIL multi_hot: got err=%0b col=%0d slice5=%0d want 1/5/0", got_err, got_col, got_rows[17:15]);
    end
    n_checks++;
    if (got_count !== 8'(exp_count)) begin
      n_fail++; $display("FAIL bad_onehot_count: got %0d want %0d", got_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    load_rows(1, 3, 5, 7, 2, 0, 6, 4);
    compute_expected();
    launch();
    for (int n = 0; n < 5; n++) begin
      start = (n == 1 || n == 3);
      @(posedge clk); #1 start = 1'b0;
      n_checks++;
      if (sol_valid !== 1'b1 || sol_rows !== exp_rows || rd_col !== 3'd0 || sol_error !== exp_err) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got vld=%0b rows=%h rd=%0d err=%0b want 1/%h/0/%0b",
                 n, sol_valid, sol_rows, rd_col, sol_error, exp_rows, exp_err);
      end
    end
    // Start coincident with the handshake must be ignored.
    start = 1'b1;
    accept();
    start = 1'b0;
    count_model();
    n_checks++;
    if (got_count !== 8'(exp_count)) begin
      n_fail++; $display("FAIL backpressure_count: got %0d want %0d", got_count, exp_count);
    end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || sol_valid !== 1'b0 || rd_col !== 3'd0 || sol_count !== 8'(exp_count)) begin
        n_fail++; $display("FAIL no_rescan[%0d]: got busy=%0b vld=%0b rd=%0d cnt=%0d want 0/0/0/%0d",
                           n, busy, sol_valid, rd_col, sol_count, exp_count);
      end
    end
  endtask

  task automatic test_random();
    int perm [8];
    int j, t, mode;
    for (int it = 0; it < 24; it++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 8; c++) perm[c] = c;
      for (int c = 7; c > 0; c--) begin
        j = $urandom_range(0, c);
        t = perm[c]; perm[c] = perm[j]; perm[j] = t;
      end
      if (mode == 0) for (int c = 0; c < 8; c++) bd[c] = 8'd1 << perm[c];
      else if (mode == 1) begin
        load_rows(0, 5, 7, 2, 6, 3, 1, 4);
        bd[$urandom_range(0, 7)] = 8'($urandom);
      end else for (int c = 0; c < 8; c++) bd[c] = 8'($urandom);
      compute_expected();
      launch();
      accept();
      count_model();
      n_checks++;
      if (got_lat != 8 || got_rows !== exp_rows || got_err !== exp_err || got_col !== exp_col || got_count !== 8'(exp_count)) begin
        n_fail++;
        $display("FAIL random[%0d]: got lat=%0d rows=%h err=%0b col=%0d cnt=%0d want 8/%h/%0b/%0d/%0d",
                 it, got_lat, got_rows, got_err, got_col, got_count, exp_rows, exp_err, exp_col, exp_count);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int seen;
    logic [2:0] first_cols [2];
    load_rows(0, 4, 7, 5, 2, 6, 1, 3);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      if (rd_col === 3'd4) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen == 0) begin n_fail++; $display("FAIL reach_col4: got rd=%0d want 4", rd_col); end
    rst = 1'b1;
    #1;
    exp_count = 0;
    n_checks++;
    if ({rd_col, busy, sol_valid, sol_rows, sol_error, err_col, sol_count} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_mid_read: got rd=%0d busy=%0b vld=%0b rows=%h err=%0b col=%0d cnt=%0d want all zero",
               rd_col, busy, sol_valid, sol_rows, sol_error, err_col, sol_count);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    first_cols[0] = rd_col;
    @(posedge clk); #1;
    first_cols[1] = rd_col;
    n_checks++;
    if (first_cols[0] !== 3'd0 || first_cols[1] !== 3'd1) begin
      n_fail++; $display("FAIL rescan_start: got %0d,%0d want 0,1", first_cols[0], first_cols[1]);
    end
    for (int n = 0; n < 12 && sol_valid !== 1'b1; n++) begin @(posedge clk); #1; end
    compute_expected();
    n_checks++;
    if (sol_valid !== 1'b1 || sol_rows !== 24'h672BE0 || sol_error !== 1'b0) begin
      n_fail++; $display("FAIL rescan_result: got vld=%0b rows=%h err=%0b want 1/672be0/0", sol_valid, sol_rows, sol_error);
    end
    accept();
    count_model();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_count = 0;
    load_rows(0, 4, 7, 5, 2, 6, 1, 3);
    compute_expected();
    for (int i = 0; i < 256; i++) begin
      launch();
      accept();
      count_model();
      if (i == 254 || i == 255) begin
        n_checks++;
        if (got_count !== 8'(exp_count)) begin
          n_fail++; $display("FAIL saturation[%0d]: got %0d want %0d", i, got_count, exp_count);
        end
      end
    end
    n_checks++;
    if (sol_count !== 8'd255) begin n_fail++; $display("FAIL saturation_final: got %0d want 255", sol_count); end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_row_conflict();
    test_diag_conflict();
    test_bad_onehot();
    test_backpressure();
    test_random();
    test_reset_mid_read();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
